// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant, binary index and valid.
// Optional ARB_LOCK_EN adds lock_i, which lets the current owner hold past its weight.
module wrr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_W       = 4,
  localparam int ID_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQUESTERS-1:0]          req_i,
  input  logic [NUM_REQUESTERS*WEIGHT_W-1:0] weight_i,
`ifdef ARB_LOCK_EN
  input  logic                               lock_i,
`endif
  output logic [NUM_REQUESTERS-1:0]          gnt_o,
  output logic                               gnt_valid_o,
  output logic [ID_W-1:0]                    gnt_id_o
);

  logic [NUM_REQUESTERS-1:0] gnt_q, gnt_d;
  logic                      valid_q, valid_d;
  logic [ID_W-1:0]           id_q, id_d;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]       cnt_q, cnt_d;
  logic [WEIGHT_W-1:0]       wl_q, wl_d;

  logic                      found_s;
  logic [ID_W-1:0]           win_s;
  logic [WEIGHT_W-1:0]       wsel_s;
  logic                      hold_s;

  // Circular scan of the request vector starting at the rotation pointer.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    wsel_s  = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQUESTERS;
      if (!found_s && req_i[idx]) begin
        found_s = 1'b1;
        win_s   = ID_W'(idx);
        wsel_s  = weight_i[idx*WEIGHT_W +: WEIGHT_W];
      end else begin
        found_s = found_s;
      end
    end
  end

  // The owner keeps the grant while still requesting and inside its tenure (or locked).
  always_comb begin
`ifdef ARB_LOCK_EN
    hold_s = valid_q && req_i[id_q] && (lock_i || (cnt_q < wl_q));
`else
    hold_s = valid_q && req_i[id_q] && (cnt_q < wl_q);
`endif
  end

  // Next-state selection: hold, fresh grant, or idle.
  always_comb begin
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wl_d    = wl_q;
    if (hold_s) begin
      // Saturate so a long lock cannot wrap the counter back below the weight.
      cnt_d = (cnt_q < wl_q) ? cnt_q + WEIGHT_W'(1) : cnt_q;
    end else if (found_s) begin
      gnt_d        = '0;
      gnt_d[win_s] = 1'b1;
      valid_d      = 1'b1;
      id_d         = win_s;
      cnt_d        = WEIGHT_W'(1);
      wl_d         = (wsel_s == '0) ? WEIGHT_W'(1) : wsel_s;
      ptr_d        = (win_s == ID_W'(NUM_REQUESTERS - 1)) ? '0 : win_s + ID_W'(1);
    end else begin
      gnt_d   = '0;
      valid_d = 1'b0;
      id_d    = '0;
      cnt_d   = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wl_q    <= '0;
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wl_q    <= wl_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_id_o    = id_q;

endmodule
